// File: rtl/puf_calib_ctrl.sv
// rtl/puf_calib_ctrl.sv - per-channel delay-PUF tune-level calibration controller
// Sweeps or binary-searches each channel's level for a ones-count nearest window/2, then holds it.
module puf_calib_ctrl #(
  parameter int N_PUF  = 16,
  parameter int K      = 5,
  parameter int LOG_CI = 16,
  parameter int SETTLE = 4,
  parameter int TOL    = 320
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    calib_start,
  input  logic [LOG_CI-1:0]       iter_cfg,
  input  logic                    mode,
  input  logic [N_PUF-1:0]        resp_i,
  output logic [N_PUF*K-1:0]      tune_level_o,
  output logic [N_PUF*LOG_CI-1:0] best_bias_o,
  output logic                    calib_busy,
  output logic                    calib_done,
  output logic [N_PUF-1:0]        calib_fail
);
  localparam logic [K-1:0]      LVL_MID     = K'(1 << (K - 1));
  localparam logic [K-1:0]      LVL_MAX     = K'((1 << K) - 1);
  localparam logic [K:0]        LAST_SWEEP  = (K+1)'((1 << K) - 1);
  localparam logic [K:0]        LAST_BIN    = (K+1)'(K - 1);
  localparam logic [LOG_CI-1:0] SETTLE_LAST = LOG_CI'(SETTLE - 1);
  localparam logic [LOG_CI-1:0] TOL_V       = LOG_CI'(TOL);

  // Search bounds need a sign bit and one headroom bit: hi may reach -1, lo may reach 2^K.
  typedef logic signed [K+1:0] bnd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SETTLE, S_COUNT, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [LOG_CI-1:0] win, half, cnt;
  logic              mode_q;
  logic [K:0]        rnd, last_rnd;
  logic [N_PUF-1:0]  fail;

  logic [K-1:0]      level     [N_PUF];
  logic [K-1:0]      best_lvl  [N_PUF];
  logic [K-1:0]      lvl_nx    [N_PUF];
  bnd_t              lo        [N_PUF];
  bnd_t              hi        [N_PUF];
  bnd_t              lo_nx     [N_PUF];
  bnd_t              hi_nx     [N_PUF];
  bnd_t              mid       [N_PUF];
  logic [LOG_CI-1:0] ones      [N_PUF];
  logic [LOG_CI-1:0] best_bias [N_PUF];
  logic [LOG_CI-1:0] bias      [N_PUF];

  assign half       = win >> 1;
  assign last_rnd   = mode_q ? LAST_BIN : LAST_SWEEP;
  assign calib_busy = state inside {S_INIT, S_SETTLE, S_COUNT, S_EVAL, S_APPLY};
  assign calib_done = (state == S_DONE);
  assign calib_fail = fail;

  always_ff @(negedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (calib_start) state_nx = S_INIT;
      S_INIT:         state_nx = S_SETTLE;
      S_SETTLE:       if (cnt == SETTLE_LAST) state_nx = S_COUNT;
      S_COUNT:        if (cnt == win - 1'b1) state_nx = S_EVAL;
      S_EVAL:         state_nx = (rnd == last_rnd) ? S_APPLY : S_SETTLE;
      S_APPLY:        state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // An exact hit moves both bounds past the level, so that channel holds from then on.
  always_comb begin
    for (int i = 0; i < N_PUF; i++) begin
      bias[i]   = (ones[i] >= half) ? (ones[i] - half) : (half - ones[i]);
      lo_nx[i]  = lo[i];
      hi_nx[i]  = hi[i];
      lvl_nx[i] = level[i];
      mid[i]    = bnd_t'(0);
      if (!mode_q) begin
        lvl_nx[i] = level[i] + 1'b1;
      end else if (lo[i] <= hi[i]) begin
        if (ones[i] >= half) hi_nx[i] = bnd_t'(level[i]) - bnd_t'(1);
        if (ones[i] <= half) lo_nx[i] = bnd_t'(level[i]) + bnd_t'(1);
        if (lo_nx[i] <= hi_nx[i]) begin
          mid[i] = (lo_nx[i] + hi_nx[i]) >>> 1;
          if (mid[i] < bnd_t'(0))               lvl_nx[i] = '0;
          else if (mid[i] > bnd_t'(LVL_MAX))    lvl_nx[i] = LVL_MAX;
          else                                  lvl_nx[i] = mid[i][K-1:0];
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      win    <= LOG_CI'(2);
      mode_q <= 1'b0;
      cnt    <= '0;
      rnd    <= '0;
      fail   <= '0;
      for (int i = 0; i < N_PUF; i++) begin
        level[i]     <= LVL_MID;
        best_lvl[i]  <= '0;
        lo[i]        <= bnd_t'(0);
        hi[i]        <= bnd_t'(LVL_MAX);
        ones[i]      <= '0;
        best_bias[i] <= '1;
      end
    end else begin
      case (state)
        S_INIT: begin
          win    <= (iter_cfg < LOG_CI'(2)) ? LOG_CI'(2) : iter_cfg;
          mode_q <= mode;
          cnt    <= '0;
          rnd    <= '0;
          fail   <= '0;
          for (int i = 0; i < N_PUF; i++) begin
            level[i]     <= mode ? LVL_MID : '0;
            best_lvl[i]  <= '0;
            lo[i]        <= bnd_t'(0);
            hi[i]        <= bnd_t'(LVL_MAX);
            ones[i]      <= '0;
            best_bias[i] <= '1;
          end
        end
        S_SETTLE: cnt <= (state_nx == S_COUNT) ? '0 : cnt + 1'b1;
        S_COUNT: begin
          cnt <= (state_nx == S_EVAL) ? '0 : cnt + 1'b1;
          for (int i = 0; i < N_PUF; i++)
            ones[i] <= ones[i] + LOG_CI'(resp_i[i]);
        end
        S_EVAL: begin
          rnd <= rnd + 1'b1;
          for (int i = 0; i < N_PUF; i++) begin
            ones[i] <= '0;
            lo[i]   <= lo_nx[i];
            hi[i]   <= hi_nx[i];
            if (bias[i] < best_bias[i]) begin
              best_bias[i] <= bias[i];
              best_lvl[i]  <= level[i];
            end
            if (state_nx == S_SETTLE) level[i] <= lvl_nx[i];
          end
        end
        S_APPLY: begin
          for (int i = 0; i < N_PUF; i++) begin
            level[i] <= best_lvl[i];
            fail[i]  <= (best_bias[i] > TOL_V);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tune_level_o = '0;
    best_bias_o  = '0;
    for (int i = 0; i < N_PUF; i++) begin
      tune_level_o[i*K +: K]           = level[i];
      best_bias_o[i*LOG_CI +: LOG_CI]  = best_bias[i];
    end
  end

endmodule

// File: tb/tb_puf_calib_ctrl.sv
// tb/tb_puf_calib_ctrl.sv - directed bench for puf_calib_ctrl
// Channel models: ch0 ones = 2*level, ch1 ones = 16-2*level over any 16-sample window.
module tb_puf_calib_ctrl;
  localparam int N_PUF  = 2;
  localparam int K      = 3;
  localparam int LOG_CI = 16;
  localparam int SETTLE = 2;
  localparam int TOL    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    calib_start = 1'b0;
  logic [LOG_CI-1:0]       iter_cfg = 16'd16;
  logic                    mode = 1'b0;
  logic [N_PUF-1:0]        resp_i;
  logic [N_PUF*K-1:0]      tune_level_o;
  logic [N_PUF*LOG_CI-1:0] best_bias_o;
  logic                    calib_busy;
  logic                    calib_done;
  logic [N_PUF-1:0]        calib_fail;

  logic                    const_ones = 1'b0;
  logic [2:0]              ph = 3'd0;
  int                      n_cmp = 0;
  int                      n_err = 0;

  puf_calib_ctrl #(
    .N_PUF(N_PUF), .K(K), .LOG_CI(LOG_CI), .SETTLE(SETTLE), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .calib_start(calib_start), .iter_cfg(iter_cfg),
    .mode(mode), .resp_i(resp_i), .tune_level_o(tune_level_o),
    .best_bias_o(best_bias_o), .calib_busy(calib_busy),
    .calib_done(calib_done), .calib_fail(calib_fail)
  );

  always #5 clk = ~clk;

  // Responses change on posedge, DUT counts on negedge.
  always @(posedge clk) ph <= ph + 3'd1;

  always_comb begin
    resp_i[0] = const_ones | (ph <  tune_level_o[2:0]);
    resp_i[1] = const_ones | (ph >= tune_level_o[5:3]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a calibration and counts negedges from the start edge until done.
  task automatic run(input logic md, input logic [LOG_CI-1:0] cfg, input int pulse_at,
                     output int lat, output logic [5:0] snap, output logic d1);
    mode     = md;
    iter_cfg = cfg;
    @(posedge clk); #1 calib_start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 calib_start = 1'b0;
    lat  = 0;
    snap = '0;
    d1   = 1'b1;
    while (lat < 1000) begin
      @(negedge clk); #1;
      lat++;
      calib_start = (lat == pulse_at);
      if (lat == pulse_at) begin
        mode     = ~md;
        iter_cfg = 16'd3;
      end
      if (lat == 1)  d1 = calib_done;
      if (lat == 30) snap = tune_level_o;
      if (calib_done) break;
    end
    calib_start = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [5:0] snap;
    logic       d1;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_tune", tune_level_o, 64'd36);
    chk("reset_bias", best_bias_o, 64'hFFFF_FFFF);
    chk("reset_busy", calib_busy, 64'd0);
    chk("reset_done", calib_done, 64'd0);
    chk("reset_fail", calib_fail, 64'd0);
    rst = 1'b0;

    run(1'b0, 16'd16, -1, lat, snap, d1);
    chk("sweep_latency", lat, 64'd154);
    chk("sweep_mid_tune", snap, 64'd9);
    chk("sweep_tune", tune_level_o, 64'd36);
    chk("sweep_bias", best_bias_o, 64'd0);
    chk("sweep_fail", calib_fail, 64'd0);
    chk("sweep_busy", calib_busy, 64'd0);

    run(1'b1, 16'd16, -1, lat, snap, d1);
    chk("bin_latency", lat, 64'd59);
    chk("bin_done_drop", d1, 64'd0);
    chk("bin_mid_tune", snap, 64'd36);
    chk("bin_tune", tune_level_o, 64'd36);
    chk("bin_bias", best_bias_o, 64'd0);
    chk("bin_fail", calib_fail, 64'd0);

    const_ones = 1'b1;
    run(1'b0, 16'd16, -1, lat, snap, d1);
    chk("const_latency", lat, 64'd154);
    chk("const_tune", tune_level_o, 64'd0);
    chk("const_bias", best_bias_o, 64'h0008_0008);
    chk("const_fail", calib_fail, 64'd3);
    const_ones = 1'b0;

    run(1'b0, 16'd0, -1, lat, snap, d1);
    chk("w2_latency", lat, 64'd42);
    chk("w2_done", calib_done, 64'd1);

    run(1'b0, 16'd16, 50, lat, snap, d1);
    chk("busy_start_latency", lat, 64'd154);
    chk("busy_start_tune", tune_level_o, 64'd36);
    chk("busy_start_bias", best_bias_o, 64'd0);
    chk("busy_start_fail", calib_fail, 64'd0);

    run(1'b0, 16'd16, -1, lat, snap, d1);
    chk("restart_latency", lat, 64'd154);
    chk("restart_done_drop", d1, 64'd0);
    chk("restart_tune", tune_level_o, 64'd36);
    chk("restart_bias", best_bias_o, 64'd0);

    mode     = 1'b0;
    iter_cfg = 16'd16;
    @(posedge clk); #1 calib_start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 calib_start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("count_busy", calib_busy, 64'd1);
    chk("count_tune", tune_level_o, 64'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_busy", calib_busy, 64'd0);
    chk("abort_done", calib_done, 64'd0);
    chk("abort_tune", tune_level_o, 64'd36);
    chk("abort_bias", best_bias_o, 64'hFFFF_FFFF);
    chk("abort_fail", calib_fail, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
